// File: rtl/cam_pkg.sv
// Shared types and sizing helpers for the camera capture sequencer.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SYNC,
    ACTIVE,
    DONE
  } cam_state_e;

  localparam int unsigned PIX_W = 16;

  localparam int unsigned QVGA_H_PIX   = 320;
  localparam int unsigned QVGA_V_LINES = 240;
  localparam int unsigned VGA_H_PIX    = 640;
  localparam int unsigned VGA_V_LINES  = 480;

  localparam int unsigned QVGA_ADDR_W = $clog2(QVGA_H_PIX * QVGA_V_LINES);
  localparam int unsigned VGA_ADDR_W  = $clog2(VGA_H_PIX * VGA_V_LINES);

  // Bits needed to hold the value max_val (never less than one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    if (max_val < 2) begin
      return 1;
    end
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// One-stage register on a camera sync line with rise/fall detect against the registered copy.
module cam_sync_edge
  import cam_pkg::*;
(
  input  logic i_pclk,
  input  logic reset,
  input  logic sig,
  output logic rise_c,
  output logic fall_c
);

  logic sig_q;

  // Previous-cycle copy of the sync line.
  always_ff @(posedge i_pclk) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign rise_c = sig & ~sig_q;
  assign fall_c = ~sig & sig_q;

endmodule

// File: rtl/cam_frame_ctrl.sv
// Capture sequencer: aligns to VSYNC and turns the pixel stream into addressed frame-buffer writes.
module cam_frame_ctrl
  import cam_pkg::*;
#(
  parameter int unsigned H_PIX     = QVGA_H_PIX,
  parameter int unsigned V_LINES   = QVGA_V_LINES,
  parameter int unsigned ADDR_W    = QVGA_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              i_pclk,
  input  logic              reset,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic              vsync,
  input  logic              href,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned FRAME_PIX = H_PIX * V_LINES;
  localparam int unsigned HCNT_W    = cnt_w(H_PIX + 1);
  localparam int unsigned VCNT_W    = cnt_w(V_LINES + 1);
  localparam int unsigned TOT_W     = cnt_w(FRAME_PIX);

  // Line counters saturate one past the expected value so a long line/frame never aliases to a good one.
  localparam logic [HCNT_W-1:0] HCNT_EXP = HCNT_W'(H_PIX);
  localparam logic [HCNT_W-1:0] HCNT_SAT = HCNT_W'(H_PIX + 1);
  localparam logic [VCNT_W-1:0] VCNT_EXP = VCNT_W'(V_LINES);
  localparam logic [VCNT_W-1:0] VCNT_SAT = VCNT_W'(V_LINES + 1);
  localparam logic [TOT_W-1:0]  TOT_EXP  = TOT_W'(FRAME_PIX);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  cam_state_e state;
  cam_state_e next_state;

  logic              cont_q;
  logic [HCNT_W-1:0] line_pix;
  logic [VCNT_W-1:0] line_cnt;
  logic [TOT_W-1:0]  pix_idx;

  logic vs_rise_c;
  logic vs_fall_c;
  logic hr_fall_c;
  logic href_rise_unused;

  logic              start_acc_c;
  logic              sync_clr_c;
  logic              pix_acc_c;
  logic              pix_wr_c;
  logic              line_end_c;
  logic              frame_end_c;
  logic              err_c;
  logic              full_c;
  logic [VCNT_W-1:0] line_cnt_nx_c;
  logic [TOT_W-1:0]  pix_total_c;

  // Lines are closed on the HREF fall; the rise is not needed.
  cam_sync_edge u_vsync_edge (
    .i_pclk (i_pclk),
    .reset  (reset),
    .sig    (vsync),
    .rise_c (vs_rise_c),
    .fall_c (vs_fall_c)
  );

  cam_sync_edge u_href_edge (
    .i_pclk (i_pclk),
    .reset  (reset),
    .sig    (href),
    .rise_c (href_rise_unused),
    .fall_c (hr_fall_c)
  );

  assign full_c = (pix_idx == TOT_EXP);

  // State register.
  always_ff @(posedge i_pclk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort overrides everything including a simultaneous start.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start)     next_state = ARM;
        ARM:     if (vsync)     next_state = SYNC;
        SYNC:    if (vs_fall_c) next_state = ACTIVE;
        ACTIVE:  if (vs_rise_c) next_state = DONE;
        DONE:    next_state = cont_q ? SYNC : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Per-state control strobes and frame/line checks feeding the registered outputs.
  always_comb begin
    start_acc_c   = 1'b0;
    sync_clr_c    = 1'b0;
    pix_acc_c     = 1'b0;
    pix_wr_c      = 1'b0;
    line_end_c    = 1'b0;
    frame_end_c   = 1'b0;
    err_c         = 1'b0;
    line_cnt_nx_c = line_cnt;
    pix_total_c   = pix_idx;
    if (!abort) begin
      case (state)
        IDLE: start_acc_c = start;
        SYNC: sync_clr_c  = vs_fall_c;
        ACTIVE: begin
          pix_acc_c   = pix_valid & href;
          pix_wr_c    = pix_acc_c & ~full_c;
          line_end_c  = hr_fall_c;
          frame_end_c = vs_rise_c;
          if (line_end_c && (line_cnt != VCNT_SAT)) begin
            line_cnt_nx_c = line_cnt + VCNT_W'(1);
          end
          if (pix_wr_c) begin
            pix_total_c = pix_idx + TOT_W'(1);
          end
          if (pix_valid && !href) begin
            err_c = 1'b1;
          end
          if (pix_acc_c && full_c) begin
            err_c = 1'b1;
          end
          if (line_end_c && (line_pix != HCNT_EXP)) begin
            err_c = 1'b1;
          end
          if (frame_end_c && ((line_cnt_nx_c != VCNT_EXP) || (pix_total_c != TOT_EXP))) begin
            err_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel, line and frame-index counters plus the latched continuous flag.
  always_ff @(posedge i_pclk) begin
    if (reset) begin
      cont_q   <= 1'b0;
      line_pix <= '0;
      line_cnt <= '0;
      pix_idx  <= '0;
    end else begin
      if (start_acc_c) begin
        cont_q <= cont;
      end
      if (sync_clr_c) begin
        line_pix <= '0;
        line_cnt <= '0;
        pix_idx  <= '0;
      end else begin
        if (line_end_c) begin
          line_pix <= '0;
        end else if (pix_acc_c && (line_pix != HCNT_SAT)) begin
          line_pix <= line_pix + HCNT_W'(1);
        end
        line_cnt <= line_cnt_nx_c;
        pix_idx  <= pix_total_c;
      end
    end
  end

  // Frame-buffer write port, one cycle behind the accepted pixel.
  always_ff @(posedge i_pclk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= BASE;
      wr_data <= '0;
    end else begin
      wr_en <= pix_wr_c;
      if (pix_wr_c) begin
        wr_addr <= BASE + ADDR_W'(pix_idx);
        wr_data <= pix_data;
      end
    end
  end

  // Status outputs: busy, frame completion pulse/count and the sticky error.
  always_ff @(posedge i_pclk) begin
    if (reset) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      frame_err  <= 1'b0;
    end else begin
      busy       <= (next_state != IDLE);
      frame_done <= frame_end_c;
      if (frame_end_c) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (start_acc_c) begin
        frame_err <= 1'b0;
      end else if (sync_clr_c && cont_q) begin
        frame_err <= 1'b0;
      end else if (err_c) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule
